// File: rtl/mlcd_rd_engine.sv
// mlcd_rd_engine: 8080 MCU-LCD read engine -- command write, dummy reads, N data reads streamed with sink backpressure.
// Define MLCD_RD_INSYNC_EN to pass mlcd_data_i through an input register before capture (needs RD_LOW >= 3).
module mlcd_rd_engine #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2,
  parameter int RD_LOW  = 4,
  parameter int RD_HIGH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic [10:0] rd_len,
  input  logic [1:0]  dummy,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        rdata_vld,
  input  logic        sink_ready,
  output logic        mlcd_cs,
  output logic        mlcd_wr,
  output logic        mlcd_rd,
  output logic        mlcd_rs,
  output logic [15:0] mlcd_data_o,
  output logic        mlcd_data_oe,
  input  logic [15:0] mlcd_data_i
);
  typedef enum logic [2:0] {IDLE, CMD_LO, CMD_HI, TURN, RD_LO, RD_HI, FIN} state_e;
  localparam int PMAX_W = WR_LOW > WR_HIGH ? WR_LOW : WR_HIGH;
  localparam int PMAX_R = RD_LOW > RD_HIGH ? RD_LOW : RD_HIGH;
  localparam int PMAX   = PMAX_W > PMAX_R ? PMAX_W : PMAX_R;
  localparam int PW     = $clog2(PMAX) + 1;
  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d, ph_lim;
  logic [15:0]   cmd_q, rdata_q, cap;
  logic [10:0]   len_q, wcnt_q;
  logic [1:0]    dum_q, dcnt_q;
  logic          rdata_vld_q, ph_end, is_dummy, all_done;
`ifdef MLCD_RD_INSYNC_EN
  logic [15:0] din_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) din_q <= '0;
    else        din_q <= mlcd_data_i;
  assign cap = din_q;
`else
  assign cap = mlcd_data_i;
`endif
  always_comb begin
    ph_lim   = state_q == CMD_LO ? PW'(WR_LOW - 1) :
               state_q == CMD_HI ? PW'(WR_HIGH - 1) :
               state_q == RD_LO  ? PW'(RD_LOW - 1) : PW'(RD_HIGH - 1);
    ph_end   = ph_q == ph_lim;
    is_dummy = dcnt_q != dum_q;
    all_done = dcnt_q == dum_q && wcnt_q == len_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  always_comb begin
    state_d = state_q;
    ph_d    = ph_end ? '0 : ph_q + 1'b1;
    case (state_q)
      IDLE:    begin
        ph_d    = '0;
        state_d = start ? CMD_LO : IDLE;
      end
      CMD_LO:  state_d = ph_end ? CMD_HI : CMD_LO;
      CMD_HI:  state_d = !ph_end ? CMD_HI : (dum_q == 2'd0 && len_q == 11'd0) ? FIN : TURN;
      TURN:    begin
        ph_d    = '0;
        state_d = RD_LO;
      end
      RD_LO:   state_d = ph_end ? RD_HI : RD_LO;
      RD_HI:   begin
        // Phase counter parks at its last value while the sink stalls us
        ph_d    = ph_end && !all_done && !sink_ready ? ph_q : ph_d;
        state_d = !ph_end ? RD_HI : all_done ? FIN : sink_ready ? RD_LO : RD_HI;
      end
      FIN:     begin
        ph_d    = '0;
        state_d = IDLE;
      end
      default: begin
        ph_d    = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_q       <= '0;
      len_q       <= '0;
      dum_q       <= '0;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
    end else begin
      rdata_vld_q <= 1'b0;
      if (state_q == IDLE && start) begin
        cmd_q  <= cmd;
        len_q  <= rd_len;
        dum_q  <= dummy;
        wcnt_q <= '0;
        dcnt_q <= '0;
      end
      // Dummy reads always come first and are dropped without a strobe
      if (state_q == RD_LO && ph_end) begin
        if (is_dummy) dcnt_q <= dcnt_q + 2'd1;
        else begin
          wcnt_q      <= wcnt_q + 11'd1;
          rdata_q     <= cap;
          rdata_vld_q <= 1'b1;
        end
      end
    end
  always_comb begin
    busy         = state_q != IDLE;
    done         = state_q == FIN;
    rdata        = rdata_q;
    rdata_vld    = rdata_vld_q;
    mlcd_cs      = state_q == IDLE || state_q == FIN;
    mlcd_wr      = state_q != CMD_LO;
    mlcd_rd      = state_q != RD_LO;
    mlcd_data_oe = state_q == CMD_LO || state_q == CMD_HI;
    mlcd_rs      = !mlcd_data_oe;
    mlcd_data_o  = mlcd_data_oe ? cmd_q : 16'h0000;
  end
endmodule

// File: tb/tb_mlcd_rd_engine.sv
// tb_mlcd_rd_engine: vector table + randomized transactions against a pad model and transaction-level reference.
module tb_mlcd_rd_engine;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sink_ready = 1'b1;
  logic [15:0] cmd = '0;
  logic [10:0] rd_len = '0;
  logic [1:0]  dummy = '0;
  logic        busy, done, rdata_vld, mlcd_cs, mlcd_wr, mlcd_rd, mlcd_rs, mlcd_data_oe;
  logic [15:0] rdata, mlcd_data_o, mlcd_data_i;
  logic [15:0] pad [128];
  logic [15:0] cur_cmd = '0;
  logic [15:0] got [$];
  int n_rd, n_wr, n_done, n_cont, n_rs, n_cmd, n_bp;
  int errors = 0, checks = 0;
  logic prev_rd = 1'b1, prev_wr = 1'b1, prev_sr = 1'b1;
  typedef struct {
    logic [15:0] cmd;
    int          dummy;
    int          len;
    int          mode;
    bit          spur;
    int          exp_done;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  mlcd_rd_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .rd_len(rd_len), .dummy(dummy),
    .busy(busy), .done(done), .rdata(rdata), .rdata_vld(rdata_vld), .sink_ready(sink_ready),
    .mlcd_cs(mlcd_cs), .mlcd_wr(mlcd_wr), .mlcd_rd(mlcd_rd), .mlcd_rs(mlcd_rs),
    .mlcd_data_o(mlcd_data_o), .mlcd_data_oe(mlcd_data_oe), .mlcd_data_i(mlcd_data_i)
  );

  // Pad model: the k-th read pulse of a transaction sees pad[k-1]
  assign mlcd_data_i = n_rd == 0 ? 16'h0000 : pad[7'(n_rd - 1)];

  always @(negedge clk) begin
    if ((mlcd_data_oe && !mlcd_rd) || (!mlcd_rd && mlcd_cs)) n_cont++;
    if (!mlcd_rs && !mlcd_data_oe) n_rs++;
    if (!mlcd_wr && mlcd_data_o !== cur_cmd) n_cmd++;
    if (!mlcd_rd && prev_rd) begin
      if (n_rd > 0 && !prev_sr) n_bp++;
      n_rd++;
    end
    if (!mlcd_wr && prev_wr) n_wr++;
    if (done) n_done++;
    if (rdata_vld) got.push_back(rdata);
    prev_rd = mlcd_rd;
    prev_wr = mlcd_wr;
    prev_sr = sink_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    n_rd = 0; n_wr = 0; n_done = 0; n_cont = 0; n_rs = 0; n_cmd = 0; n_bp = 0;
    got.delete();
  endtask

  task automatic fill_pad(input bit id_pattern);
    for (int i = 0; i < 128; i++) pad[i] = 16'($urandom);
    if (id_pattern) begin
      pad[0] = 16'hAAAA; pad[1] = 16'h0000; pad[2] = 16'h0093; pad[3] = 16'h0041;
    end
  endtask

  task automatic run(input vec_t v);
    int cyc = 0, dcyc = 0, drop = 0, bad = 0;
    bit dropped = 0;
    clr();
    cur_cmd = v.cmd;
    cmd = v.cmd; dummy = 2'(v.dummy); rd_len = 11'(v.len); sink_ready = 1'b1; start = 1'b1;
    while (dcyc == 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("busy_rise", 32'(busy), 1);
      if (v.spur && cyc == 8) begin
        start = 1'b1;
        cmd = 16'h1234;
      end
      if (v.mode == 1) sink_ready = 1'($urandom_range(0, 1));
      if (v.mode == 2) begin
        if (!dropped && got.size() >= 2) begin
          dropped = 1;
          drop = 10;
        end
        sink_ready = drop == 0;
        if (drop > 0) drop--;
      end
      if (done) dcyc = cyc;
    end
    chk("done_seen", 32'(dcyc != 0), 1);
    if (v.exp_done != 0) chk("done_cycle", dcyc, v.exp_done);
    @(posedge clk); #1;
    chk("busy_fall", 32'(busy), 0);
    sink_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < v.len; i++)
      if (i >= got.size() || got[i] !== pad[v.dummy + i]) bad++;
    chk("done_pulses", n_done, 1);
    chk("wr_pulses", n_wr, 1);
    chk("rd_pulses", n_rd, v.dummy + v.len);
    chk("word_count", got.size(), v.len);
    chk("word_data", bad, 0);
    chk("contention", n_cont, 0);
    chk("rs_phase", n_rs, 0);
    chk("cmd_bus", n_cmd, 0);
    chk("bp_rd_hold", n_bp, 0);
    if (v.len > 0) chk("rdata_hold", rdata, pad[v.dummy + v.len - 1]);
  endtask

  initial begin
    vec_t v;
    int w;
    // Expected done cycle: 1 + WR_LOW + WR_HIGH, plus TURN and 7 cycles per read when any read happens
    vt[0] = '{16'h00D3, 1, 3, 0, 1'b0, 34};
    vt[1] = '{16'h0029, 0, 0, 0, 1'b0, 5};
    vt[2] = '{16'h002E, 1, 1, 0, 1'b0, 20};
    vt[3] = '{16'h002E, 0, 4, 2, 1'b0, 0};
    vt[4] = '{16'h002E, 2, 3, 0, 1'b1, 41};
    vt[5] = '{16'h00DA, 3, 0, 0, 1'b0, 27};
    vt[6] = '{16'h00DB, 0, 1, 0, 1'b0, 13};
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, rdata_vld, mlcd_cs, mlcd_wr, mlcd_rd, mlcd_rs, mlcd_data_oe}, 8'b0001_1110);
    chk("reset_data", {rdata, mlcd_data_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      fill_pad(i == 0);
      run(vt[i]);
    end
    // Asynchronous reset in the middle of a read strobe
    fill_pad(0);
    clr();
    cur_cmd = 16'h002E;
    cmd = 16'h002E; dummy = 2'd0; rd_len = 11'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (mlcd_rd !== 1'b0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rd_low_reached", 32'(mlcd_rd), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid", {mlcd_cs, mlcd_rd, mlcd_data_oe, busy}, 4'b1100);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", n_done, 0);
    fill_pad(0);
    run(vt[6]);
    for (int r = 0; r < 24; r++) begin
      v.cmd = 16'($urandom);
      v.dummy = $urandom_range(0, 3);
      v.len = $urandom_range(1, 64);
      v.mode = $urandom_range(0, 1);
      v.spur = r % 4 == 0;
      v.exp_done = v.mode == 0 ? 6 + (v.dummy + v.len) * 7 : 0;
      fill_pad(0);
      run(v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mlcd_rd_engine.md
# mlcd_rd_engine

Intel 8080 read-side engine for the MCU LCD bus, the read counterpart of the GRAM write path. On a start request it writes one command word (e.g. 0x002E read-GRAM, 0x00D3 read-ID), releases the data bus, performs a programmable number of discarded dummy reads, then reads N 16-bit words and streams them to a sink with ready backpressure. It sits between the LCD pad tri-state logic and the ID-detect and GRAM-readback consumers.

## Interface
- WR_LOW, 2: clk cycles mlcd_wr held low per command write (≥1)
- WR_HIGH, 2: clk cycles mlcd_wr held high after the command write (≥1)
- RD_LOW, 4: clk cycles mlcd_rd held low per read (≥2)
- RD_HIGH, 3: clk cycles mlcd_rd held high between reads (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; accepted only while busy=0
- cmd  in  16  command word, latched on accepted start
- rd_len  in  11  number of data words to deliver (0..2047), latched on start
- dummy  in  2  number of dummy reads to discard (0..3), latched on start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the transaction completes
- rdata  out  16  captured data word
- rdata_vld  out  1  one-cycle strobe; rdata valid
- sink_ready  in  1  consumer can take another word
- mlcd_cs  out  1  chip select, active low
- mlcd_wr  out  1  write strobe, active low
- mlcd_rd  out  1  read strobe, active low
- mlcd_rs  out  1  0 = command, 1 = data
- mlcd_data_o  out  16  bus drive value
- mlcd_data_oe  out  1  1 = drive bus with mlcd_data_o
- mlcd_data_i  in  16  bus sample value from pads

## Operation
- Reset values: busy=0, done=0, rdata=0, rdata_vld=0, mlcd_cs=1, mlcd_wr=1, mlcd_rd=1, mlcd_rs=1, mlcd_data_o=0, mlcd_data_oe=0.
- States: IDLE, CMD_LO, CMD_HI, TURN, RD_LO, RD_HI, FIN.
- IDLE: start=1 → latch cmd/rd_len/dummy, word counter=0, go CMD_LO. Start while busy is ignored.
- CMD_LO: cs=0, rs=0, oe=1, data_o=cmd, wr=0 for WR_LOW cycles → CMD_HI.
- CMD_HI: wr=1, data_o/oe held for WR_HIGH cycles → TURN. If dummy+rd_len=0, → FIN instead.
- TURN: one cycle, oe=0, rs=1, bus released → RD_LO.
- RD_LO: rd=0 for RD_LOW cycles; mlcd_data_i captured on the final RD_LO cycle edge → RD_HI.
- RD_HI: rd=1 for RD_HIGH cycles. Words with index < dummy are discarded; others raise rdata_vld for one cycle on the first RD_HI cycle. At the end of RD_HI: all dummy+rd_len reads done → FIN; else if sink_ready=1 → RD_LO; else hold rd=1, cs=0 until sink_ready=1.
- FIN: cs=1, rs=1, done=1 for one cycle, busy=0 next cycle → IDLE.
- Counters: 11-bit data-word counter plus 2-bit dummy counter; no wrap (2047 max). Phase counter sized for max(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH).
- Reset mid-transaction: all outputs return to reset values asynchronously; no done pulse.

## Timing
- Accepted start at cycle 0 → cs=0, wr=0 from cycle 1.
- With defaults, dummy=1, rd_len=1: CMD_LO 1-2, CMD_HI 3-4, TURN 5, dummy RD_LO 6-9, RD_HI 10-12, data RD_LO 13-16, rdata_vld at 17, RD_HI 17-19, done at 20.
- Read period = RD_LOW+RD_HIGH cycles when sink_ready stays high.
- rdata holds its value until the next valid word.
- sink_ready is sampled only at the end of RD_HI; never drop a strobed word.
- Bus contention: oe=0 and rd=1 throughout TURN; oe is never 1 while rd=0.

## Configuration
- MLCD_RD_INSYNC_EN defined: mlcd_data_i passes through one input register before capture. RD_LO capture uses the registered value, so RD_LOW ≥3 is required; rdata_vld timing is unchanged.
- Undefined: mlcd_data_i is captured directly on the final RD_LO edge.

## Test plan
- Read ID: cmd=0x00D3, dummy=1, rd_len=3, pad model returns 0xAAAA, 0x0000, 0x0093, 0x0041 → rdata_vld ×3 with 0x0000, 0x0093, 0x0041. done one pulse, mlcd_data_o=0x00D3 during CMD_LO.
- Zero length: cmd=0x0029, dummy=0, rd_len=0 → one wr pulse, no rd pulses, done at cycle 5 (defaults).
- Backpressure: rd_len=4, sink_ready low for 10 cycles after the 2nd word → rd stays high, no extra strobes, all 4 words delivered in order.
- Start while busy: second start with cmd=0x1234 mid-read → ignored, bus never shows 0x1234.
- Reset mid-read: rst_n low during RD_LO → cs=1, rd=1, oe=0 immediately, no done. A new start afterward completes normally.
- Contention check: assert oe&~rd never true, and rs=0 only during CMD_LO/CMD_HI, across random rd_len 1..64 and dummy 0..3.
